// File: rtl/ahb_pkg.sv
// Shared AHB encodings, arbiter state type and burst-length decode.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_NONSEQ = 2'd1,
    ARB_SEQ    = 2'd2,
    ARB_BUSY   = 2'd3
  } arb_state_e;

  // Beats in a burst; undefined-length INCR is treated as a single beat.
  function automatic logic [4:0] burst_len(input logic [2:0] hburst);
    logic [4:0] len;
    case (hburst)
      HBURST_SINGLE, HBURST_INCR:   len = 5'd1;
      HBURST_WRAP4,  HBURST_INCR4:  len = 5'd4;
      HBURST_WRAP8,  HBURST_INCR8:  len = 5'd8;
      HBURST_WRAP16, HBURST_INCR16: len = 5'd16;
      default:                      len = 5'd1;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first request found searching upward
// from last_grant+1, wrapping modulo N_REQ.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N_REQ-1:0] gnt
);

  logic             found;
  logic [IDX_W-1:0] idx;

  // Rotating priority scan producing a one-hot grant.
  // NOTE: every variable written here gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      idx = IDX_W'((int'(last_grant) + off) % N_REQ);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_req_arbiter.sv
// Shares one AHB-Lite master port between N_REQ requesters. A grant is
// taken only from ARB_IDLE and held for the whole burst.
module ahb_req_arbiter
  import ahb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic [N_REQ-1:0]     REQ_VALID,
  input  logic [N_REQ*32-1:0]  REQ_ADDR,
  input  logic [N_REQ*32-1:0]  REQ_WDATA,
  input  logic [N_REQ-1:0]     REQ_WRITE,
  input  logic [N_REQ*2-1:0]   REQ_SIZE,
  input  logic [N_REQ*3-1:0]   REQ_BURST,
  output logic [N_REQ-1:0]     REQ_GNT,
  output logic [N_REQ-1:0]     REQ_DONE,
  output logic [N_REQ-1:0]     REQ_ERR,
  output logic [31:0]          REQ_RDATA,
  output logic [31:0]          M_PADDR,
  output logic [31:0]          M_PWDATA,
  output logic                 M_PWRITE,
  output logic [1:0]           M_PSIZE,
  output logic [1:0]           M_PTRANS,
  output logic [2:0]           M_PBURST,
  input  logic                 M_PREADY,
  input  logic                 M_PRESP,
  input  logic [31:0]          M_PRDATA
);

  localparam int         IDX_W    = $clog2(N_REQ);
  localparam logic [4:0] BEAT_MAX = 5'd16;

  arb_state_e        state;
  logic [N_REQ-1:0]  gnt_q;
  logic [IDX_W-1:0]  g_idx;
  logic [IDX_W-1:0]  last_grant;
  logic [4:0]        beat_cnt;

  logic [N_REQ-1:0]  pick;
  logic [IDX_W-1:0]  pick_idx;
  logic              in_grant;
  logic              g_valid;
  logic [4:0]        g_len;
  logic              beat_fire;
  logic              last_beat;
  logic [4:0]        beat_next;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req        (REQ_VALID),
    .last_grant (last_grant),
    .gnt        (pick)
  );

  // One-hot pick to index, used to steer the output mux.
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick[i]) pick_idx = IDX_W'(i);
    end
  end

  // Beat bookkeeping for the currently granted requester. In ARB_SEQ a
  // beat only completes while that requester still has VALID high.
  always_comb begin
    in_grant  = (state != ARB_IDLE);
    g_valid   = REQ_VALID[g_idx];
    g_len     = burst_len(REQ_BURST[g_idx*3 +: 3]);
    beat_fire = M_PREADY && ((state == ARB_NONSEQ) ||
                             ((state == ARB_SEQ) && g_valid));
    last_beat = (beat_cnt + 5'd1) >= g_len;
    beat_next = (beat_cnt >= BEAT_MAX) ? BEAT_MAX : beat_cnt + 5'd1;
  end

  // Master-port drive: mux of the granted requester, zero when idle.
  always_comb begin
    M_PADDR   = in_grant ? REQ_ADDR[g_idx*32 +: 32]  : 32'd0;
    M_PWDATA  = in_grant ? REQ_WDATA[g_idx*32 +: 32] : 32'd0;
    M_PWRITE  = in_grant ? REQ_WRITE[g_idx]          : 1'b0;
    M_PSIZE   = in_grant ? REQ_SIZE[g_idx*2 +: 2]    : 2'd0;
    M_PBURST  = in_grant ? REQ_BURST[g_idx*3 +: 3]   : 3'd0;
    case (state)
      ARB_NONSEQ: M_PTRANS = HTRANS_NONSEQ;
      ARB_SEQ:    M_PTRANS = HTRANS_SEQ;
      ARB_BUSY:   M_PTRANS = HTRANS_BUSY;
      default:    M_PTRANS = HTRANS_IDLE;
    endcase
    REQ_GNT   = gnt_q;
    REQ_DONE  = (beat_fire && !M_PRESP) ? gnt_q : '0;
    REQ_ERR   = (beat_fire &&  M_PRESP) ? gnt_q : '0;
    REQ_RDATA = beat_fire ? M_PRDATA : 32'd0;
  end

  // Arbitration and burst FSM.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state      <= ARB_IDLE;
      gnt_q      <= '0;
      g_idx      <= '0;
      beat_cnt   <= '0;
      last_grant <= IDX_W'(N_REQ - 1);
    end else begin
      case (state)
        ARB_IDLE: begin
          if (|REQ_VALID) begin
            gnt_q    <= pick;
            g_idx    <= pick_idx;
            beat_cnt <= '0;
            state    <= ARB_NONSEQ;
          end
        end
        ARB_NONSEQ, ARB_SEQ: begin
          if (beat_fire) begin
            beat_cnt <= beat_next;
            if (M_PRESP || last_beat) begin
              state      <= ARB_IDLE;
              gnt_q      <= '0;
              last_grant <= g_idx;
            end else begin
              state <= ARB_SEQ;
            end
          end else if ((state == ARB_SEQ) && !g_valid) begin
            state <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (g_valid) state <= ARB_SEQ;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_req_arbiter.sv
// Self-checking bench for ahb_req_arbiter: directed scenarios plus a
// randomized run, all checked against a transaction-level model.
module tb_ahb_req_arbiter;

  localparam int N = 4;

  logic              HCLK = 1'b0;
  logic              HRESETn;
  logic [N-1:0]      REQ_VALID;
  logic [N*32-1:0]   REQ_ADDR;
  logic [N*32-1:0]   REQ_WDATA;
  logic [N-1:0]      REQ_WRITE;
  logic [N*2-1:0]    REQ_SIZE;
  logic [N*3-1:0]    REQ_BURST;
  logic [N-1:0]      REQ_GNT;
  logic [N-1:0]      REQ_DONE;
  logic [N-1:0]      REQ_ERR;
  logic [31:0]       REQ_RDATA;
  logic [31:0]       M_PADDR;
  logic [31:0]       M_PWDATA;
  logic              M_PWRITE;
  logic [1:0]        M_PSIZE;
  logic [1:0]        M_PTRANS;
  logic [2:0]        M_PBURST;
  logic              M_PREADY;
  logic              M_PRESP;
  logic [31:0]       M_PRDATA;

  ahb_req_arbiter #(.N_REQ(N)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .REQ_VALID (REQ_VALID),
    .REQ_ADDR  (REQ_ADDR),
    .REQ_WDATA (REQ_WDATA),
    .REQ_WRITE (REQ_WRITE),
    .REQ_SIZE  (REQ_SIZE),
    .REQ_BURST (REQ_BURST),
    .REQ_GNT   (REQ_GNT),
    .REQ_DONE  (REQ_DONE),
    .REQ_ERR   (REQ_ERR),
    .REQ_RDATA (REQ_RDATA),
    .M_PADDR   (M_PADDR),
    .M_PWDATA  (M_PWDATA),
    .M_PWRITE  (M_PWRITE),
    .M_PSIZE   (M_PSIZE),
    .M_PTRANS  (M_PTRANS),
    .M_PBURST  (M_PBURST),
    .M_PREADY  (M_PREADY),
    .M_PRESP   (M_PRESP),
    .M_PRDATA  (M_PRDATA)
  );

  always #5 HCLK = ~HCLK;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: who owns the port, how many beats finished, whether paused.
  int m_owner;
  int m_beats;
  int m_last;
  bit m_paused;

  // Last sampled DUT outputs, for scenario-level checks.
  logic [N-1:0] obs_gnt, obs_done, obs_err;
  logic [1:0]   obs_ptrans;
  logic [31:0]  obs_addr;

  function automatic int len_of(input logic [2:0] b);
    int lens [8] = '{1, 1, 4, 4, 8, 8, 16, 16};
    return lens[b];
  endfunction

  function automatic logic bit_of(input logic [N-1:0] v, input int i);
    logic [N-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  task automatic model_reset();
    m_owner  = -1;
    m_beats  = 0;
    m_paused = 1'b0;
    m_last   = N - 1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [31:0] a,
                         input logic [31:0] d, input logic w,
                         input logic [1:0] s, input logic [2:0] b);
    REQ_VALID = (REQ_VALID & ~(N'(1) << i)) | (N'(v) << i);
    REQ_WRITE = (REQ_WRITE & ~(N'(1) << i)) | (N'(w) << i);
    REQ_ADDR[i*32 +: 32]  = a;
    REQ_WDATA[i*32 +: 32] = d;
    REQ_SIZE[i*2 +: 2]    = s;
    REQ_BURST[i*3 +: 3]   = b;
  endtask

  // One clock: compare DUT against the model mid-cycle, then advance model.
  task automatic tick();
    logic [N-1:0] e_gnt, e_done, e_err;
    logic [1:0]   e_tr;
    logic [69:0]  e_bus, a_bus;
    bit           fire;
    int           len;
    @(negedge HCLK);
    e_gnt = '0;
    e_tr  = 2'b00;
    e_bus = '0;
    fire  = 1'b0;
    len   = 1;
    if (m_owner >= 0) begin
      e_gnt = N'(1) << m_owner;
      e_tr  = (m_beats == 0) ? 2'b10 : (m_paused ? 2'b01 : 2'b11);
      e_bus = {REQ_ADDR[m_owner*32 +: 32], REQ_WDATA[m_owner*32 +: 32],
               bit_of(REQ_WRITE, m_owner), REQ_SIZE[m_owner*2 +: 2],
               REQ_BURST[m_owner*3 +: 3]};
      fire  = M_PREADY && (m_beats == 0 || (!m_paused && bit_of(REQ_VALID, m_owner)));
      len   = len_of(REQ_BURST[m_owner*3 +: 3]);
    end
    e_done = (fire && !M_PRESP) ? e_gnt : '0;
    e_err  = (fire &&  M_PRESP) ? e_gnt : '0;
    a_bus  = {M_PADDR, M_PWDATA, M_PWRITE, M_PSIZE, M_PBURST};

    n_checks++;
    if (REQ_GNT !== e_gnt) $display("FAIL gnt @%0t: got %b expected %b", $time, REQ_GNT, e_gnt);
    else n_pass++;
    n_checks++;
    if (M_PTRANS !== e_tr) $display("FAIL ptrans @%0t: got %b expected %b", $time, M_PTRANS, e_tr);
    else n_pass++;
    n_checks++;
    if (REQ_DONE !== e_done) $display("FAIL done @%0t: got %b expected %b", $time, REQ_DONE, e_done);
    else n_pass++;
    n_checks++;
    if (REQ_ERR !== e_err) $display("FAIL err @%0t: got %b expected %b", $time, REQ_ERR, e_err);
    else n_pass++;
    n_checks++;
    if (a_bus !== e_bus) $display("FAIL mbus @%0t: got %h expected %h", $time, a_bus, e_bus);
    else n_pass++;
    if (fire) begin
      n_checks++;
      if (REQ_RDATA !== M_PRDATA) $display("FAIL rdata @%0t: got %h expected %h", $time, REQ_RDATA, M_PRDATA);
      else n_pass++;
    end

    obs_gnt    = REQ_GNT;
    obs_done   = REQ_DONE;
    obs_err    = REQ_ERR;
    obs_ptrans = M_PTRANS;
    obs_addr   = M_PADDR;

    @(posedge HCLK);
    if (m_owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        if (m_owner < 0 && bit_of(REQ_VALID, (m_last + k) % N)) begin
          m_owner  = (m_last + k) % N;
          m_beats  = 0;
          m_paused = 1'b0;
        end
      end
    end else if (fire) begin
      if (M_PRESP || m_beats + 1 >= len) begin
        m_last  = m_owner;
        m_owner = -1;
      end else begin
        m_beats++;
      end
    end else if (m_beats > 0) begin
      if (!m_paused && !bit_of(REQ_VALID, m_owner)) m_paused = 1'b1;
      else if (m_paused && bit_of(REQ_VALID, m_owner)) m_paused = 1'b0;
    end
    #1;
  endtask

  task automatic apply_reset();
    HRESETn   = 1'b0;
    REQ_VALID = '0;
    M_PREADY  = 1'b1;
    M_PRESP   = 1'b0;
    #1;
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    model_reset();
  endtask

  // Let any open burst finish, then confirm the port is idle.
  task automatic quiesce();
    M_PREADY = 1'b1;
    M_PRESP  = 1'b0;
    for (int k = 0; k < 40 && m_owner >= 0; k++) begin
      REQ_VALID = N'(1) << m_owner;
      tick();
    end
    REQ_VALID = '0;
    tick();
    n_checks++;
    if (obs_gnt !== '0 || obs_ptrans !== 2'b00)
      $display("FAIL quiesce: got gnt %b trans %b expected 0000/00", obs_gnt, obs_ptrans);
    else n_pass++;
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, $urandom, $urandom, 1'b1, 2'b10, 3'b000);
    M_PREADY = 1'b1;
    M_PRESP  = 1'b0;
    M_PRDATA = $urandom;
    #1;
    n_checks++;
    if ({REQ_GNT, REQ_DONE, REQ_ERR, M_PTRANS} !== '0)
      $display("FAIL reset_ctl: got %h expected 0", {REQ_GNT, REQ_DONE, REQ_ERR, M_PTRANS});
    else n_pass++;
    n_checks++;
    if ({M_PADDR, M_PWDATA, M_PWRITE, M_PSIZE, M_PBURST, REQ_RDATA} !== '0)
      $display("FAIL reset_bus: got %h expected 0", {M_PADDR, M_PWDATA, M_PWRITE, M_PSIZE, M_PBURST, REQ_RDATA});
    else n_pass++;
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    model_reset();
    tick();
    tick();
    n_checks++;
    if (obs_gnt !== 4'b0001) $display("FAIL first_grant: got %b expected 0001", obs_gnt);
    else n_pass++;
    n_checks++;
    if (obs_ptrans !== 2'b10) $display("FAIL first_nonseq: got %b expected 10", obs_ptrans);
    else n_pass++;
    quiesce();
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_g [6] = '{4'b0000, 4'b0001, 4'b0000, 4'b0100, 4'b0000, 4'b0001};
    logic [1:0]   exp_t [6] = '{2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10};
    apply_reset();
    set_req(0, 1'b1, 32'h0000_1000, $urandom, 1'b1, 2'b10, 3'b000);
    set_req(2, 1'b1, 32'h0000_2000, $urandom, 1'b0, 2'b10, 3'b000);
    for (int c = 0; c < 6; c++) begin
      tick();
      n_checks++;
      if (obs_gnt !== exp_g[c]) $display("FAIL rr_gnt[%0d]: got %b expected %b", c, obs_gnt, exp_g[c]);
      else n_pass++;
      n_checks++;
      if (obs_ptrans !== exp_t[c]) $display("FAIL rr_trans[%0d]: got %b expected %b", c, obs_ptrans, exp_t[c]);
      else n_pass++;
    end
    quiesce();
  endtask

  task automatic test_incr4_stall();
    logic [1:0] exp_tr [6] = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11};
    logic [1:0] trace [$];
    logic [1:0] after_tr = 2'bxx;
    logic [31:0] first_addr = 32'hxxxx_xxxx;
    int done_cnt = 0;
    int stall = 0;
    bit seen_idle = 1'b0;
    set_req(1, 1'b1, 32'h0000_0100, $urandom, 1'b1, 2'b10, 3'b011);
    for (int c = 0; c < 30 && !seen_idle; c++) begin
      M_PREADY = !(done_cnt == 1 && stall < 2);
      if (!M_PREADY) stall++;
      tick();
      if (obs_gnt != '0) begin
        if (trace.size() == 0) first_addr = obs_addr;
        trace.push_back(obs_ptrans);
      end else if (trace.size() > 0) begin
        seen_idle = 1'b1;
        after_tr  = obs_ptrans;
      end
      if (obs_done[1]) done_cnt++;
      if (done_cnt == 4) REQ_VALID = '0;
    end
    M_PREADY = 1'b1;
    n_checks++;
    if (done_cnt !== 4) $display("FAIL incr4_done: got %0d expected 4", done_cnt);
    else n_pass++;
    n_checks++;
    if (first_addr !== 32'h0000_0100) $display("FAIL incr4_addr: got %h expected 00000100", first_addr);
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (trace.size() <= i) $display("FAIL incr4_trace[%0d]: got none expected %b", i, exp_tr[i]);
      else if (trace[i] !== exp_tr[i]) $display("FAIL incr4_trace[%0d]: got %b expected %b", i, trace[i], exp_tr[i]);
      else n_pass++;
    end
    n_checks++;
    if (after_tr !== 2'b00) $display("FAIL incr4_idle: got %b expected 00", after_tr);
    else n_pass++;
    quiesce();
  endtask

  task automatic test_busy();
    int done_cnt = 0;
    int drop = 0;
    int busy_cnt = 0;
    bit was_busy = 1'b0;
    bit after_set = 1'b0;
    logic [1:0] after_busy = 2'bxx;
    M_PREADY = 1'b1;
    set_req(3, 1'b1, 32'h0000_3000, $urandom, 1'b0, 2'b10, 3'b100);
    for (int c = 0; c < 60 && done_cnt < 8; c++) begin
      if (done_cnt == 3 && drop < 3) begin
        REQ_VALID[3] = 1'b0;
        drop++;
      end else begin
        REQ_VALID[3] = 1'b1;
      end
      M_PRDATA = $urandom;
      tick();
      if (obs_ptrans == 2'b01) begin
        busy_cnt++;
        was_busy = 1'b1;
      end else if (was_busy && !after_set) begin
        after_busy = obs_ptrans;
        after_set  = 1'b1;
      end
      if (obs_done[3]) done_cnt++;
    end
    REQ_VALID = '0;
    n_checks++;
    if (busy_cnt !== 3) $display("FAIL busy_cycles: got %0d expected 3", busy_cnt);
    else n_pass++;
    n_checks++;
    if (after_busy !== 2'b11) $display("FAIL busy_resume: got %b expected 11", after_busy);
    else n_pass++;
    n_checks++;
    if (done_cnt !== 8) $display("FAIL wrap8_beats: got %0d expected 8", done_cnt);
    else n_pass++;
    quiesce();
  endtask

  task automatic test_error();
    int done_cnt = 0;
    int err_cnt = 0;
    bit others = 1'b0;
    M_PREADY = 1'b1;
    set_req(2, 1'b1, 32'h0000_4000, $urandom, 1'b1, 2'b10, 3'b111);
    for (int c = 0; c < 40 && err_cnt == 0; c++) begin
      M_PRESP = (done_cnt == 1);
      tick();
      if (obs_gnt[2] && !others) begin
        set_req(3, 1'b1, 32'h0000_5000, $urandom, 1'b0, 2'b10, 3'b000);
        set_req(0, 1'b1, 32'h0000_6000, $urandom, 1'b0, 2'b10, 3'b000);
        others = 1'b1;
      end
      if (obs_done[2]) done_cnt++;
      err_cnt += $countones(obs_err);
    end
    M_PRESP = 1'b0;
    REQ_VALID[2] = 1'b0;
    tick();
    n_checks++;
    if (err_cnt !== 1 || done_cnt !== 1)
      $display("FAIL err_pulse: got err %0d done %0d expected 1/1", err_cnt, done_cnt);
    else n_pass++;
    n_checks++;
    if (obs_gnt !== 4'b0000 || obs_ptrans !== 2'b00 || obs_err !== 4'b0000)
      $display("FAIL err_idle: got gnt %b trans %b err %b expected idle", obs_gnt, obs_ptrans, obs_err);
    else n_pass++;
    tick();
    n_checks++;
    if (obs_gnt !== 4'b1000) $display("FAIL err_rotate: got %b expected 1000", obs_gnt);
    else n_pass++;
    quiesce();
  endtask

  task automatic test_reset_mid();
    int done_cnt = 0;
    M_PREADY = 1'b1;
    M_PRESP  = 1'b0;
    set_req(2, 1'b1, 32'h0000_7000, $urandom, 1'b1, 2'b10, 3'b101);
    for (int c = 0; c < 30 && done_cnt < 4; c++) begin
      tick();
      if (obs_done[2]) done_cnt++;
    end
    #2;
    n_checks++;
    if (REQ_GNT !== 4'b0100 || M_PTRANS !== 2'b11)
      $display("FAIL mid_burst: got gnt %b trans %b expected 0100/11", REQ_GNT, M_PTRANS);
    else n_pass++;
    HRESETn = 1'b0;
    #1;
    n_checks++;
    if ({REQ_GNT, REQ_DONE, REQ_ERR, M_PTRANS, REQ_RDATA} !== '0)
      $display("FAIL mid_reset_ctl: got %h expected 0", {REQ_GNT, REQ_DONE, REQ_ERR, M_PTRANS, REQ_RDATA});
    else n_pass++;
    n_checks++;
    if ({M_PADDR, M_PWDATA, M_PWRITE, M_PSIZE, M_PBURST} !== '0)
      $display("FAIL mid_reset_bus: got %h expected 0", {M_PADDR, M_PWDATA, M_PWRITE, M_PSIZE, M_PBURST});
    else n_pass++;
    model_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, $urandom, $urandom, 1'b0, 2'b10, 3'b000);
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    tick();
    tick();
    n_checks++;
    if (obs_gnt !== 4'b0001) $display("FAIL restart_grant: got %b expected 0001", obs_gnt);
    else n_pass++;
    quiesce();
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (i != m_owner)
          set_req(i, 1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
        else
          REQ_VALID = (REQ_VALID & ~(N'(1) << i)) | (N'($urandom_range(0, 9) != 0) << i);
      end
      M_PREADY = ($urandom_range(0, 3) != 0);
      M_PRESP  = ($urandom_range(0, 15) == 0);
      M_PRDATA = $urandom;
      tick();
    end
    quiesce();
  endtask

  initial begin
    HRESETn   = 1'b0;
    REQ_VALID = '0;
    REQ_ADDR  = '0;
    REQ_WDATA = '0;
    REQ_WRITE = '0;
    REQ_SIZE  = '0;
    REQ_BURST = '0;
    M_PREADY  = 1'b0;
    M_PRESP   = 1'b0;
    M_PRDATA  = '0;
    model_reset();

    test_reset();
    test_round_robin();
    test_incr4_stall();
    test_busy();
    test_error();
    test_reset_mid();
    test_random();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
